// File: rtl/a2bus_read_responder.sv
// Apple II slot read responder: samples each bus cycle's address, asks a client whether it claims
// the read, and drives the returned byte through Phi0 plus a short hold. INH support: A2BUS_READ_RESPONDER_INH_EN.
module a2bus_read_responder #(
  parameter int CLOCK_SPEED_HZ = 54_000_000,
  parameter int ADDR_COUNT     = 18,
  parameter int DRIVE_START    = 4,
  parameter int HOLD_COUNT     = 3
) (
  input  logic        clk_logic_i,
  input  logic        system_reset_n_i,
  input  logic        phi0_i,
  input  logic        phi0_posedge_i,
  input  logic        phi0_negedge_i,
  input  logic        enable_i,
  input  logic [15:0] a2_a_i,
  input  logic        a2_rw_n_i,
  output logic        rd_req_o,
  output logic [15:0] rd_addr_o,
  input  logic        rd_ack_i,
  input  logic        rd_claim_i,
  input  logic [7:0]  rd_data_i,
  input  logic        rd_inh_i,
  output logic [7:0]  a2_d_o,
  output logic        a2_d_oe_o,
  output logic        a2_inh_n_o,
  output logic        miss_o
);

  // Each ~1.023 MHz bus cycle has two phases, so this is the logic-clock length of one phase.
  localparam int PHASE_CLOCKS = CLOCK_SPEED_HZ / 2_046_000;

  if (HOLD_COUNT < 1 || HOLD_COUNT >= ADDR_COUNT || ADDR_COUNT >= PHASE_CLOCKS
      || DRIVE_START >= PHASE_CLOCKS) begin : g_param_check
    $error("a2bus_read_responder: phase timing parameters do not fit one bus phase");
  end

`ifdef A2BUS_READ_RESPONDER_INH_EN
  localparam logic INH_EN = 1'b1;
`else
  localparam logic INH_EN = 1'b0;
`endif

  localparam logic [5:0] CNT_MAX   = 6'd63;
  localparam logic [5:0] ADDR_CNT  = 6'(ADDR_COUNT);
  localparam logic [5:0] DRIVE_CNT = 6'(DRIVE_START);
  localparam logic [5:0] HOLD_CNT  = 6'(HOLD_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_REQ,
    ST_READY,
    ST_DRIVE
  } state_t;

  state_t      state_reg;
  logic [5:0]  phase_cnt_reg;
  logic [5:0]  hold_cnt_reg;
  logic        rd_req_reg;
  logic [15:0] rd_addr_reg;
  logic [7:0]  d_reg;
  logic        oe_reg;
  logic        inh_n_reg;
  logic        miss_reg;

  logic stalled;
  logic addr_sample;
  logic deadline;
  logic drive_now;

  assign stalled     = (phase_cnt_reg == CNT_MAX);
  assign addr_sample = (phase_cnt_reg == ADDR_CNT) && !phi0_i;
  assign deadline    = (phase_cnt_reg == DRIVE_CNT) && phi0_i;
  // On the Phi0-rise clock the counter still holds the Phi1 count, so that clock is excluded.
  assign drive_now   = phi0_i && !phi0_posedge_i && (phase_cnt_reg >= DRIVE_CNT);

  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n_i) begin
      state_reg     <= ST_IDLE;
      phase_cnt_reg <= CNT_MAX;
      hold_cnt_reg  <= '0;
      rd_req_reg    <= 1'b0;
      rd_addr_reg   <= '0;
      d_reg         <= '0;
      oe_reg        <= 1'b0;
      inh_n_reg     <= 1'b1;
      miss_reg      <= 1'b0;
    end else begin
      rd_req_reg <= 1'b0;
      miss_reg   <= 1'b0;

      if (phi0_posedge_i || phi0_negedge_i) begin
        phase_cnt_reg <= '0;
      end else if (!stalled) begin
        phase_cnt_reg <= phase_cnt_reg + 6'd1;
      end

      // Hold tail runs on its own so the next cycle's address phase can proceed meanwhile.
      if (hold_cnt_reg != '0) begin
        hold_cnt_reg <= hold_cnt_reg - 6'd1;
        if (hold_cnt_reg == 6'd1) begin
          oe_reg    <= 1'b0;
          inh_n_reg <= 1'b1;
        end
      end

      if (stalled && state_reg != ST_IDLE) begin
        state_reg    <= ST_IDLE;
        oe_reg       <= 1'b0;
        hold_cnt_reg <= '0;
        inh_n_reg    <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (phi0_negedge_i) state_reg <= ST_ADDR;
          end
          ST_ADDR: begin
            if (addr_sample) begin
              rd_addr_reg <= a2_a_i;
              if (a2_rw_n_i && enable_i) begin
                rd_req_reg <= 1'b1;
                state_reg  <= ST_REQ;
              end else begin
                state_reg <= ST_IDLE;
                inh_n_reg <= 1'b1;
              end
            end
          end
          ST_REQ: begin
            if (phi0_negedge_i) begin
              state_reg <= ST_ADDR;
            end else if (rd_ack_i) begin
              if (rd_claim_i) begin
                d_reg     <= rd_data_i;
                inh_n_reg <= ~(INH_EN & rd_inh_i);
                state_reg <= ST_READY;
              end else begin
                state_reg <= ST_IDLE;
                inh_n_reg <= 1'b1;
              end
            end else if (deadline) begin
              miss_reg  <= 1'b1;
              state_reg <= ST_IDLE;
              inh_n_reg <= 1'b1;
            end
          end
          ST_READY: begin
            if (phi0_negedge_i) begin
              state_reg <= ST_ADDR;
            end else if (drive_now) begin
              state_reg <= ST_DRIVE;
              oe_reg    <= 1'b1;
            end
          end
          ST_DRIVE: begin
            if (phi0_negedge_i) begin
              state_reg    <= ST_ADDR;
              hold_cnt_reg <= HOLD_CNT;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_req_o   = rd_req_reg;
  assign rd_addr_o  = rd_addr_reg;
  assign a2_d_o     = d_reg;
  assign a2_d_oe_o  = oe_reg;
  assign a2_inh_n_o = inh_n_reg;
  assign miss_o     = miss_reg;

endmodule

// File: tb/tb_a2bus_read_responder.sv
// Randomized bench for a2bus_read_responder: a transaction-flag model predicts every output each
// clock, and directed bus cycles pin the key timings with hand-computed values.
module tb_a2bus_read_responder;

  localparam int ADDR_COUNT  = 18;
  localparam int DRIVE_START = 4;
  localparam int HOLD_COUNT  = 3;
`ifdef A2BUS_READ_RESPONDER_INH_EN
  localparam bit INH_EN = 1'b1;
`else
  localparam bit INH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phi0, phi0_pos, phi0_neg, enable;
  logic [15:0] a2_a;
  logic        rw_n;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack, rd_claim, rd_inh;
  logic [7:0]  rd_data;
  logic [7:0]  a2_d;
  logic        a2_d_oe, a2_inh_n, miss;

  always #5 clk = ~clk;

  a2bus_read_responder dut (
    .clk_logic_i      (clk),
    .system_reset_n_i (rst_n),
    .phi0_i           (phi0),
    .phi0_posedge_i   (phi0_pos),
    .phi0_negedge_i   (phi0_neg),
    .enable_i         (enable),
    .a2_a_i           (a2_a),
    .a2_rw_n_i        (rw_n),
    .rd_req_o         (rd_req),
    .rd_addr_o        (rd_addr),
    .rd_ack_i         (rd_ack),
    .rd_claim_i       (rd_claim),
    .rd_data_i        (rd_data),
    .rd_inh_i         (rd_inh),
    .a2_d_o           (a2_d),
    .a2_d_oe_o        (a2_d_oe),
    .a2_inh_n_o       (a2_inh_n),
    .miss_o           (miss)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: which stage of a read transaction is pending, plus the bus-phase age.
  int          m_age;
  bit          m_armed, m_waiting, m_loaded, m_driving;
  int          m_hold;
  logic        m_req, m_miss, m_oe, m_inh_n;
  logic [15:0] m_addr;
  logic [7:0]  m_d;

  task automatic model_reset();
    m_age = 63; m_armed = 0; m_waiting = 0; m_loaded = 0; m_driving = 0; m_hold = 0;
    m_req = 0; m_miss = 0; m_oe = 0; m_inh_n = 1; m_addr = 16'h0000; m_d = 8'h00;
  endtask

  task automatic model_to_idle();
    m_armed = 0; m_waiting = 0; m_loaded = 0; m_driving = 0; m_inh_n = 1'b1;
  endtask

  task automatic model_step();
    bit idle;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_req = 0; m_miss = 0;
    idle = !(m_armed || m_waiting || m_loaded || m_driving);
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin m_oe = 0; m_inh_n = 1; end
    end
    if (m_age == 63 && !idle) begin
      model_to_idle(); m_oe = 0; m_hold = 0;
    end else if (phi0_neg && (m_waiting || m_loaded || m_driving)) begin
      if (m_driving) m_hold = HOLD_COUNT;
      m_waiting = 0; m_loaded = 0; m_driving = 0; m_armed = 1;
    end else if (idle) begin
      if (phi0_neg) m_armed = 1;
    end else if (m_armed) begin
      if (m_age == ADDR_COUNT && !phi0) begin
        m_addr = a2_a; m_armed = 0;
        if (rw_n && enable) begin m_req = 1; m_waiting = 1; end
        else model_to_idle();
      end
    end else if (m_waiting) begin
      if (rd_ack) begin
        m_waiting = 0;
        if (rd_claim) begin
          m_d = rd_data; m_loaded = 1;
          if (INH_EN && rd_inh) m_inh_n = 0;
        end else model_to_idle();
      end else if (m_age == DRIVE_START && phi0) begin
        m_miss = 1; model_to_idle();
      end
    end else if (m_loaded) begin
      if (phi0 && !phi0_pos && m_age >= DRIVE_START) begin
        m_loaded = 0; m_driving = 1; m_oe = 1;
      end
    end
    if (phi0_pos || phi0_neg) m_age = 0;
    else if (m_age < 63) m_age = m_age + 1;
  endtask

  always @(negedge clk) begin
    if (chk_en)
      check("outputs", {rd_req, rd_addr, a2_d, a2_d_oe, a2_inh_n, miss},
            {m_req, m_addr, m_d, m_oe, m_inh_n, m_miss});
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic        rec_req [0:63];
  logic        rec_oe  [0:63];
  logic        rec_miss[0:63];
  logic        rec_inh [0:63];
  logic [15:0] rec_addr[0:63];
  logic [7:0]  rec_d   [0:63];
  int n_req, n_oe, n_miss;

  task automatic record(input int k);
    rec_req[k] = rd_req; rec_oe[k] = a2_d_oe; rec_miss[k] = miss;
    rec_inh[k] = a2_inh_n; rec_addr[k] = rd_addr; rec_d[k] = a2_d;
    n_req += int'(rd_req); n_oe += int'(a2_d_oe); n_miss += int'(miss);
  endtask

  // One bus cycle: Phi1 for p1 clocks then Phi0 for p0 clocks. Address/R-W are only valid on the
  // sampling clock; ack payload is junk except on the ack clock.
  task automatic bus_cycle(input logic [15:0] addr, input bit rw, input bit en, input int ack_pos,
                           input bit claim, input logic [7:0] data, input bit inh,
                           input int p1, input int p0, input int stop_at);
    n_req = 0; n_oe = 0; n_miss = 0;
    for (int k = 0; k < p1 + p0 && k < stop_at; k++) begin
      phi0     = (k >= p1);
      phi0_neg = (k == 0);
      phi0_pos = (k == p1);
      enable   = en;
      a2_a     = (k == ADDR_COUNT + 1) ? addr : 16'($urandom);
      rw_n     = (k == ADDR_COUNT + 1) ? rw : 1'($urandom);
      rd_ack   = (k == ack_pos);
      rd_claim = rd_ack ? claim : 1'($urandom);
      rd_data  = rd_ack ? data : 8'($urandom);
      rd_inh   = rd_ack ? inh : 1'($urandom);
      cyc();
      record(k);
    end
  endtask

  task automatic idle_cycles(input int n, input bit level);
    n_req = 0; n_oe = 0; n_miss = 0;
    for (int m = 0; m < n; m++) begin
      phi0 = level; phi0_neg = 0; phi0_pos = 0; rd_ack = 0;
      a2_a = 16'($urandom); rw_n = 1'($urandom);
      cyc();
      if (m < 64) record(m);
    end
  endtask

  initial begin
    int p1, p0, ack;
    rst_n = 0; phi0 = 0; phi0_pos = 0; phi0_neg = 0; enable = 1; a2_a = 16'h0;
    rw_n = 1; rd_ack = 0; rd_claim = 0; rd_data = 8'h0; rd_inh = 0;
    model_reset();
    for (int i = 0; i < 3; i++) cyc();
    chk_en = 1'b1;
    check("reset_req", rd_req, 1'b0);
    check("reset_addr", rd_addr, 16'h0000);
    check("reset_data", a2_d, 8'h00);
    check("reset_oe", a2_d_oe, 1'b0);
    check("reset_inh_n", a2_inh_n, 1'b1);
    check("reset_miss", miss, 1'b0);
    rst_n = 1;
    idle_cycles(5, 1'b0);

    // Write cycle: no request, no drive
    bus_cycle(16'hC0E0, 1'b0, 1'b1, -1, 1'b1, 8'h11, 1'b0, 26, 26, 1000);
    check("write_req_count", n_req, 0);
    check("write_oe_count", n_oe, 0);

    // Claimed read of $C0E0, ack at Phi0 count 2, data $A5
    bus_cycle(16'hC0E0, 1'b1, 1'b1, 26 + 3, 1'b1, 8'hA5, 1'b0, 26, 26, 1000);
    check("rd_req_before", rec_req[ADDR_COUNT], 1'b0);
    check("rd_req_at18", rec_req[ADDR_COUNT + 1], 1'b1);
    check("rd_addr_at18", rec_addr[ADDR_COUNT + 1], 16'hC0E0);
    check("oe_before_cnt4", rec_oe[26 + 4], 1'b0);
    check("oe_at_cnt4", rec_oe[26 + 5], 1'b1);
    check("data_a5", rec_d[26 + 5], 8'hA5);
    check("oe_phi0_tail", rec_oe[26 + 25], 1'b1);

    // Declined read of $C100; its Phi1 carries the previous hold tail
    bus_cycle(16'hC100, 1'b1, 1'b1, 26 + 2, 1'b0, 8'h77, 1'b0, 26, 26, 1000);
    check("hold_oe_2", rec_oe[2], 1'b1);
    check("hold_oe_3", rec_oe[3], 1'b0);
    check("decline_oe_count", n_oe, HOLD_COUNT);
    check("decline_miss", n_miss, 0);
    check("decline_addr", rec_addr[ADDR_COUNT + 1], 16'hC100);

    // No ack: single miss at Phi0 count 4
    bus_cycle(16'hC0E0, 1'b1, 1'b1, -1, 1'b1, 8'h00, 1'b0, 25, 27, 1000);
    check("miss_at_cnt4", rec_miss[25 + 5], 1'b1);
    check("miss_count", n_miss, 1);
    check("miss_oe_count", n_oe, 0);

    // Ack exactly at the deadline: accepted, drive one clock late
    bus_cycle(16'hC0E0, 1'b1, 1'b1, 26 + 5, 1'b1, 8'h5A, 1'b0, 26, 26, 1000);
    check("late_ack_oe_cnt4", rec_oe[26 + 5], 1'b0);
    check("late_ack_oe_cnt5", rec_oe[26 + 6], 1'b1);
    check("late_ack_miss", n_miss, 0);

    // INH request at $D000
    bus_cycle(16'hD000, 1'b1, 1'b1, 26 + 1, 1'b1, 8'hC3, 1'b1, 26, 26, 1000);
    check("inh_at_ack", rec_inh[26 + 1], INH_EN ? 1'b0 : 1'b1);
    bus_cycle(16'h0000, 1'b0, 1'b1, -1, 1'b0, 8'h00, 1'b0, 26, 26, 1000);
    check("inh_in_hold", rec_inh[2], INH_EN ? 1'b0 : 1'b1);
    check("inh_released", rec_inh[3], 1'b1);

    // Bus clock stops mid-drive: release when the phase counter saturates
    bus_cycle(16'hC0E0, 1'b1, 1'b1, 26 + 2, 1'b1, 8'h96, 1'b0, 26, 26, 26 + 9);
    check("stall_driving", rec_oe[26 + 8], 1'b1);
    idle_cycles(60, 1'b1);
    check("stall_oe_62", rec_oe[54], 1'b1);
    check("stall_oe_63", rec_oe[55], 1'b0);

    // Recovery from stall, then reset during drive
    bus_cycle(16'hC0E0, 1'b1, 1'b1, 26 + 3, 1'b1, 8'h42, 1'b0, 26, 26, 1000);
    bus_cycle(16'hC0E0, 1'b1, 1'b1, 26 + 2, 1'b1, 8'h3C, 1'b0, 26, 26, 26 + 10);
    check("pre_reset_oe", rec_oe[26 + 9], 1'b1);
    check("pre_reset_data", rec_d[26 + 9], 8'h3C);
    rst_n = 0; phi0_pos = 0; phi0_neg = 0; rd_ack = 0;
    cyc();
    check("reset_mid_oe", a2_d_oe, 1'b0);
    check("reset_mid_data", a2_d, 8'h00);
    rst_n = 1;
    idle_cycles(3, 1'b1);

    // Randomized bus cycles
    for (int t = 0; t < 60; t++) begin
      p1 = int'($urandom_range(24, 28));
      p0 = int'($urandom_range(24, 28));
      case ($urandom_range(0, 3))
        0: ack = -1;
        1: ack = int'($urandom_range(0, p1 + p0 - 1));
        default: ack = int'($urandom_range(ADDR_COUNT + 1, p1 + DRIVE_START + 3));
      endcase
      bus_cycle(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0), ack,
                1'($urandom), 8'($urandom), 1'($urandom), p1, p0, 1000);
      if ($urandom_range(0, 9) == 0) idle_cycles(int'($urandom_range(1, 20)), phi0);
    end
    idle_cycles(4, phi0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
